inst_decode: RTL and testbench

INST_DECODE -- requirements
Module: inst_decode

---
 rtl/inst_decode_pkg.sv | 53 +++++
 rtl/inst_dec_comb.sv | 49 ++++
 rtl/inst_decode.sv | 103 ++++++++++
 tb/tb_inst_decode.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/inst_decode_pkg.sv
// Shared decode constants and the decoded-entry payload for the decode stage.
// The type codes are also used by the immediate sign-extender.
package inst_decode_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TYPE_W = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 25;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  // Instruction format codes
  localparam logic [TYPE_W-1:0] INST_NONE = 5'd0;
  localparam logic [TYPE_W-1:0] INST_R    = 5'd1;
  localparam logic [TYPE_W-1:0] INST_I    = 5'd2;
  localparam logic [TYPE_W-1:0] INST_S    = 5'd3;
  localparam logic [TYPE_W-1:0] INST_B    = 5'd4;
  localparam logic [TYPE_W-1:0] INST_U    = 5'd5;
  localparam logic [TYPE_W-1:0] INST_J    = 5'd6;

  // Opcode constants
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_SRX = 3'b101;

  // One decoded FIFO entry
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [TYPE_W-1:0] inst_type;
    logic [IMM_W-1:0]  imm;
    logic              shift_imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/inst_dec_comb.sv
// Pure combinational instruction decoder.
// Ports: pc/inst (fetched PC and raw instruction) -> entry_c (decoded entry).
module inst_dec_comb
  import inst_decode_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output dec_t            entry_c
);

  logic [OPC_W-1:0]  opcode;
  logic [F3_W-1:0]   funct3;
  logic [TYPE_W-1:0] inst_type;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Opcode to format map; unknown opcodes fall through to NONE
  always_comb begin
    inst_type = INST_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                      inst_type = INST_U;
      OPC_JAL:                                 inst_type = INST_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_FENCE, OPC_SYSTEM:                   inst_type = INST_I;
      OPC_BRANCH:                              inst_type = INST_B;
      OPC_STORE:                               inst_type = INST_S;
      OPC_OP:                                  inst_type = INST_R;
      default:                                 inst_type = INST_NONE;
    endcase
  end

  always_comb begin
    entry_c           = '0;
    entry_c.pc        = pc;
    entry_c.inst_type = inst_type;
    entry_c.imm       = inst[31:7];
    entry_c.shift_imm = (opcode == OPC_OP_IMM) &&
                        ((funct3 == F3_SLL) || (funct3 == F3_SRX));
    entry_c.rs1       = inst[19:15];
    entry_c.rs2       = inst[24:20];
    entry_c.rd        = inst[11:7];
    entry_c.opcode    = opcode;
    entry_c.funct3    = funct3;
    entry_c.funct7    = inst[31:25];
    entry_c.illegal   = (inst_type == INST_NONE) || (inst[1:0] != 2'b11);
  end

endmodule

// File: rtl/inst_decode.sv
// Decode stage: decodes fetched instructions and buffers them in a 2-entry FIFO.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_pc/in_inst fetch side;
// flush drops everything; out_valid/out_ready plus decoded head-entry fields
// (out_pc, out_inst_type, out_imm, out_shift_imm, out_rs1/rs2/rd,
// out_opcode/funct3/funct7, out_illegal) toward execute.
module inst_decode
  import inst_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_inst_type,
  output logic [24:0] out_imm,
  output logic        out_shift_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic        out_illegal
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_FULL = 2'd2;

  logic [CNT_W-1:0] count;
  logic             wr_ptr;
  logic             rd_ptr;
  dec_t             mem [2];
  dec_t             new_entry_c;
  dec_t             head_c;
  logic             push;
  logic             pop;

  inst_dec_comb u_dec (
    .pc      (in_pc),
    .inst    (in_inst),
    .entry_c (new_entry_c)
  );

  // Ready depends only on occupancy, never on out_ready
  assign in_ready  = (count != CNT_FULL) & ~rst;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // FIFO state; flush wins over any concurrent push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry_c;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry, forced to zero when empty so stale storage never leaks out
  always_comb begin
    head_c = '0;
    if (out_valid) begin
      head_c = mem[rd_ptr];
    end
  end

  assign out_pc        = head_c.pc;
  assign out_inst_type = head_c.inst_type;
  assign out_imm       = head_c.imm;
  assign out_shift_imm = head_c.shift_imm;
  assign out_rs1       = head_c.rs1;
  assign out_rs2       = head_c.rs2;
  assign out_rd        = head_c.rd;
  assign out_opcode    = head_c.opcode;
  assign out_funct3    = head_c.funct3;
  assign out_funct7    = head_c.funct7;
  assign out_illegal   = head_c.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: directed scenarios plus random traffic,
// checked against a queue-based model of the decode buffer.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_inst_type;
  logic [24:0] out_imm;
  logic        out_shift_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: entries held as {pc, inst}, oldest first, capacity two
  logic [63:0] q[$];

  inst_decode dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst_type(out_inst_type), .out_imm(out_imm), .out_shift_imm(out_shift_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_type(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17:                      return 5'd5;
      7'h6F:                             return 5'd6;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return 5'd2;
      7'h63:                             return 5'd4;
      7'h23:                             return 5'd3;
      7'h33:                             return 5'd1;
      default:                           return 5'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's head entry
  task automatic check_all();
    logic [31:0] i;
    logic [31:0] p;
    logic        e;
    e = (q.size() == 0);
    i = e ? 32'h0 : q[0][31:0];
    p = e ? 32'h0 : q[0][63:32];
    chk("in_ready",  32'(in_ready),  32'(!rst && q.size() != 2));
    chk("out_valid", 32'(out_valid), 32'(!e));
    chk("out_pc",    out_pc, p);
    chk("out_type",  32'(out_inst_type), e ? 32'h0 : 32'(ref_type(i)));
    chk("out_imm",   32'(out_imm), i >> 7);
    chk("out_shift", 32'(out_shift_imm),
        32'(!e && i[6:0] == 7'h13 && (i[14:12] == 3'b001 || i[14:12] == 3'b101)));
    chk("out_regs",  {17'h0, out_rs1, out_rs2, out_rd}, {17'h0, i[19:15], i[24:20], i[11:7]});
    chk("out_raw",   {15'h0, out_funct7, out_funct3, out_opcode}, {15'h0, i[31:25], i[14:12], i[6:0]});
    chk("out_illegal", 32'(out_illegal),
        32'(!e && (ref_type(i) == 5'd0 || i[1:0] != 2'b11)));
  endtask

  // One clock of stimulus: drive, check, clock, update model
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    #1;
    check_all();
    do_push = v && (q.size() != 2);
    do_pop  = rdy && (q.size() != 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({pc, inst});
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h63, 7'h23, 7'h33, 7'h13};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    check_all();
    @(posedge clk); #1; rst = 1'b0;

    // addi x1, x0, 5 into empty FIFO
    step(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);
    chk("addi_type", 32'(out_inst_type), 32'd2);
    chk("addi_rd",   32'(out_rd), 32'd1);
    chk("addi_imm",  32'(out_imm), 32'h00500093 >> 7);
    chk("addi_shamt", 32'(out_shift_imm), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to two with out_ready low: slli then jal
    step(1'b1, 32'h200, 32'h00209113, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h0040006F, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_shift", 32'(out_shift_imm), 32'd1);
    step(1'b1, 32'h208, 32'h00000013, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop_in_ready", 32'(in_ready), 32'd1);
    chk("after_pop_type", 32'(out_inst_type), 32'd6);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming at count 1
    step(1'b1, 32'h300, rand_inst(), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 32'h304 + 32'(4 * k), rand_inst(), 1'b1, 1'b0);
    chk("stream_count1", 32'(q.size()), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush at count 2 with a concurrent push
    step(1'b1, 32'h400, rand_inst(), 1'b0, 1'b0);
    step(1'b1, 32'h404, rand_inst(), 1'b0, 1'b0);
    step(1'b1, 32'h408, 32'h00000033, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Illegal encodings flow through
    step(1'b1, 32'h500, 32'h0000007F, 1'b0, 1'b0);
    chk("ill7f_flag", 32'(out_illegal), 32'd1);
    step(1'b1, 32'h504, 32'h00000010, 1'b1, 1'b0);
    chk("ill10_flag", 32'(out_illegal), 32'd1);
    chk("ill10_type", 32'(out_inst_type), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-cycle at count 2
    step(1'b1, 32'h600, rand_inst(), 1'b0, 1'b0);
    step(1'b1, 32'h604, rand_inst(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2; rst = 1'b1; #1;
    q.delete();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    check_all();
    @(posedge clk); #1; rst = 1'b0;
    step(1'b1, 32'h700, 32'h000000B7, 1'b0, 1'b0);
    chk("post_rst_pc", out_pc, 32'h700);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom, rand_inst(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
